alu_issue_ctrl: RTL and testbench

Initiator-side controller for the 4-bit registered ALU. It accepts operation requests on a valid/ready channel and drives Opcode/A/B into the ALU one operation per cycle. It tracks in-flight operations across the ALU's fixed latency and captures each C into a result FIFO. Results are returned in order on a valid/ready response channel with tag and overflow flag.

---
 rtl/alu_issue_pkg.sv | 42 ++++
 rtl/alu_rsp_fifo.sv | 69 ++++++
 rtl/alu_issue_ctrl.sv | 114 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared types and helpers for the ALU issue controller.
//   W / TAG_W    : operand width (ALU result is W+1 bits) and request tag width
//   op_e         : ALU opcode encoding
//   fifo_entry_t : one queued result {c, tag, ovf}
//   track_t      : one in-flight tracking stage {valid, tag, op}
//   calc_ovf     : signed overflow of a W-bit add/sub result held in W+1 bits
package alu_issue_pkg;

  localparam int W     = 4;
  localparam int TAG_W = 3;

  typedef enum logic [1:0] {
    OP_ADD    = 2'd0,
    OP_SUB    = 2'd1,
    OP_ROR_A  = 2'd2,
    OP_RXOR_B = 2'd3
  } op_e;

  typedef struct packed {
    logic [W:0]       c;
    logic [TAG_W-1:0] tag;
    logic             ovf;
  } fifo_entry_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    op_e              op;
  } track_t;

  // The result no longer fits W signed bits when the two top bits disagree.
  // Reductions produce 0/1 and can never overflow.
  function automatic logic calc_ovf(input op_e op, input logic [W:0] c);
    logic ovf_s;
    case (op)
      OP_ADD, OP_SUB: ovf_s = (c[W] != c[W-1]);
      default:        ovf_s = 1'b0;
    endcase
    return ovf_s;
  endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// alu_rsp_fifo: synchronous result FIFO, DEPTH entries (power of 2).
//   clk, reset      : clock, synchronous active-high reset (empties the FIFO)
//   wr_en, wr_data  : push an entry (ignored only when full with no pop)
//   rd_en, rd_data  : pop the head entry; rd_data is 0 while empty
//   count           : number of stored entries
// Push and pop in the same cycle are both performed.
module alu_rsp_fifo
  import alu_issue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  fifo_entry_t   wr_data,
  input  logic          rd_en,
  output fifo_entry_t   rd_data,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  fifo_entry_t   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          empty_s;
  logic          full_s;
  logic          do_rd_s;
  logic          do_wr_s;

  assign empty_s = (count_r == '0);
  assign full_s  = (count_r == CW'(DEPTH));
  assign do_rd_s = rd_en && !empty_s;
  // A pop in the same cycle frees the slot, so a full FIFO may still accept.
  assign do_wr_s = wr_en && (!full_s || do_rd_s);
  assign rd_data = empty_s ? '0 : mem_r[rd_ptr_r];
  assign count   = count_r;

  // Storage array write port; contents are don't-care while unoccupied.
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_wr_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_rd_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_wr_s, do_rd_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: initiator-side controller for the registered ALU.
//   clk, reset                 : clock, synchronous active-high reset
//   req_valid/req_ready        : request handshake with req_opcode/a/b/tag
//   alu_opcode/alu_a/alu_b     : registered operands towards the ALU
//   alu_c                      : ALU result, valid ALU_LAT cycles after operands
//   rsp_valid/rsp_ready        : in-order response handshake with rsp_c/tag/ovf
//   busy                       : an operation is in flight or a result is queued
// Requests are admitted only while FIFO entries + in-flight ops < DEPTH, so
// every in-flight op owns a reserved FIFO slot and no result is ever dropped.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_opcode,
  input  logic [W-1:0]     req_a,
  input  logic [W-1:0]     req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [1:0]       alu_opcode,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  input  logic [W:0]       alu_c,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W:0]       rsp_c,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_ovf,
  output logic             busy
);

  localparam int CW = $clog2(DEPTH + 1);

  track_t        pipe_r [ALU_LAT+1];
  logic [CW-1:0] inflight_r;
  logic [CW-1:0] fifo_count_s;
  logic [CW:0]   used_s;
  logic          accept_s;
  logic          wr_s;
  logic          pop_s;
  fifo_entry_t   wr_entry_s;
  fifo_entry_t   rd_entry_s;

  assign used_s    = {1'b0, fifo_count_s} + {1'b0, inflight_r};
  assign req_ready = !reset && (used_s < (CW+1)'(DEPTH));
  assign accept_s  = req_valid && req_ready;
  // The last tracking stage lines up with the cycle its C is on alu_c.
  assign wr_s      = pipe_r[ALU_LAT].valid;
  assign rsp_valid = (fifo_count_s != '0);
  assign pop_s     = rsp_valid && rsp_ready;
  assign busy      = (inflight_r != '0) || rsp_valid;

  assign wr_entry_s.c   = alu_c;
  assign wr_entry_s.tag = pipe_r[ALU_LAT].tag;
  assign wr_entry_s.ovf = calc_ovf(pipe_r[ALU_LAT].op, alu_c);

  assign rsp_c   = rd_entry_s.c;
  assign rsp_tag = rd_entry_s.tag;
  assign rsp_ovf = rd_entry_s.ovf;

  // Operand issue, in-flight tracking pipeline and in-flight count.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_opcode <= 2'd0;
      alu_a      <= '0;
      alu_b      <= '0;
      inflight_r <= '0;
      for (int i = 0; i <= ALU_LAT; i++) begin
        pipe_r[i] <= '0;
      end
    end else begin
      // Operands are only presented for the cycle after an accept.
      if (accept_s) begin
        alu_opcode <= req_opcode;
        alu_a      <= req_a;
        alu_b      <= req_b;
      end else begin
        alu_opcode <= 2'd0;
        alu_a      <= '0;
        alu_b      <= '0;
      end
      pipe_r[0].valid <= accept_s;
      pipe_r[0].tag   <= req_tag;
      pipe_r[0].op    <= op_e'(req_opcode);
      for (int i = 1; i <= ALU_LAT; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
      // A FIFO write hands the op's reserved slot from in-flight to queued.
      case ({accept_s, wr_s})
        2'b10:   inflight_r <= inflight_r + CW'(1);
        2'b01:   inflight_r <= inflight_r - CW'(1);
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  alu_rsp_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_s),
    .wr_data (wr_entry_s),
    .rd_en   (pop_s),
    .rd_data (rd_entry_s),
    .count   (fifo_count_s)
  );

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: self-checking bench for alu_issue_ctrl with a behavioural
// ALU (1-cycle registered) and an in-order expected-result queue.
module tb_alu_issue_ctrl;

  typedef struct packed {
    logic [4:0] c;
    logic [2:0] tag;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_opcode = 2'd0;
  logic [3:0] req_a = 4'd0;
  logic [3:0] req_b = 4'd0;
  logic [2:0] req_tag = 3'd0;
  logic [1:0] alu_opcode;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [4:0] alu_c;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [4:0] rsp_c;
  logic [2:0] rsp_tag;
  logic       rsp_ovf;
  logic       busy;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];
  // values sampled in the current step (state after the previous edge)
  logic       s_req_ready, s_rsp_valid, s_busy, s_acc, s_pop, s_ovf, e_ok;
  logic [1:0] s_alu_op;
  logic [3:0] s_alu_a, s_alu_b;
  logic [4:0] s_c;
  logic [2:0] s_tag;
  exp_t       e;

  alu_issue_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_tag    (req_tag),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_c      (alu_c),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_c      (rsp_c),
    .rsp_tag    (rsp_tag),
    .rsp_ovf    (rsp_ovf),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Result of one operation from plain signed integer arithmetic.
  function automatic exp_t ref_model(input logic [1:0] op, input logic [3:0] a,
                                     input logic [3:0] b, input logic [2:0] tag);
    exp_t res;
    int sa, sb, r;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      2'd0:    r = sa + sb;
      2'd1:    r = sa - sb;
      2'd2:    r = (a != 4'd0) ? 1 : 0;
      default: r = $countones(b) % 2;
    endcase
    res.c   = r[4:0];
    res.tag = tag;
    res.ovf = (op < 2'd2) && (r > 7 || r < -8);
    return res;
  endfunction

  // Behavioural registered ALU, one cycle of latency.
  always @(posedge clk) begin
    if (reset) alu_c <= 5'd0;
    else       alu_c <= ref_model(alu_opcode, alu_a, alu_b, 3'd0).c;
  end

  // One clock cycle: drive inputs, sample outputs, advance the model.
  task automatic step(input logic rst, input logic v, input logic [1:0] op,
                      input logic [3:0] a, input logic [3:0] b,
                      input logic [2:0] tag, input logic rr);
    @(negedge clk);
    reset = rst; req_valid = v; req_opcode = op; req_a = a; req_b = b;
    req_tag = tag; rsp_ready = rr;
    #1;
    s_req_ready = req_ready; s_rsp_valid = rsp_valid; s_busy = busy;
    s_alu_op = alu_opcode; s_alu_a = alu_a; s_alu_b = alu_b;
    s_c = rsp_c; s_tag = rsp_tag; s_ovf = rsp_ovf;
    s_acc = !rst && v && req_ready;
    s_pop = !rst && rsp_valid && rr;
    e_ok = 1'b0;
    e = '0;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (s_pop && exp_q.size() > 0) begin
        e_ok = 1'b1;
        e = exp_q.pop_front();
      end
      if (s_acc) exp_q.push_back(ref_model(op, a, b, tag));
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 2'd1, 4'd3, 4'd2, 3'd1, 1'b1);
    step(1'b1, 1'b1, 2'd1, 4'd3, 4'd2, 3'd1, 1'b1);
    checks++;
    if (s_req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %0b want 0", s_req_ready); end
    checks++;
    if (s_rsp_valid !== 1'b0 || s_busy !== 1'b0) begin
      errors++; $display("FAIL reset_status: rsp_valid=%0b busy=%0b want 0 0", s_rsp_valid, s_busy);
    end
    checks++;
    if (s_alu_op !== 2'd0 || s_alu_a !== 4'd0 || s_alu_b !== 4'd0) begin
      errors++; $display("FAIL reset_alu: op=%0d a=%0h b=%0h want 0 0 0", s_alu_op, s_alu_a, s_alu_b);
    end
    step(1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 3'd0, 1'b1);
    checks++;
    if (s_req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %0b want 1", s_req_ready); end
  endtask

  task automatic test_single_add();
    logic [3:0] av [3] = '{4'd7, 4'b1000, 4'd7};
    logic [3:0] bv [3] = '{4'd7, 4'b1000, 4'b1000};
    logic [2:0] tv [3] = '{3'd5, 3'd6, 3'd7};
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 2'd0, av[k], bv[k], tv[k], 1'b1);
      checks++;
      if (s_acc !== 1'b1) begin errors++; $display("FAIL add_accept[%0d]: got %0b want 1", k, s_acc); end
      step(1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 3'd0, 1'b1);
      checks++;
      if (s_alu_a !== av[k] || s_alu_b !== bv[k] || s_alu_op !== 2'd0 || s_rsp_valid !== 1'b0) begin
        errors++; $display("FAIL add_issue[%0d]: a=%0h b=%0h op=%0d rv=%0b want a=%0h b=%0h op=0 rv=0",
                           k, s_alu_a, s_alu_b, s_alu_op, s_rsp_valid, av[k], bv[k]);
      end
      step(1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 3'd0, 1'b1);
      checks++;
      if (s_alu_a !== 4'd0 || s_alu_b !== 4'd0 || s_rsp_valid !== 1'b0) begin
        errors++; $display("FAIL add_idle[%0d]: a=%0h b=%0h rv=%0b want 0 0 0", k, s_alu_a, s_alu_b, s_rsp_valid);
      end
      step(1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 3'd0, 1'b1);
      checks++;
      if (!s_pop || !e_ok || s_c !== e.c || s_tag !== e.tag || s_ovf !== e.ovf) begin
        errors++; $display("FAIL add_rsp[%0d]: got v=%0b c=%0h tag=%0d ovf=%0b want c=%0h tag=%0d ovf=%0b",
                           k, s_pop, s_c, s_tag, s_ovf, e.c, e.tag, e.ovf);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] ov [3] = '{2'd1, 2'd2, 2'd3};
    logic [3:0] av [3] = '{4'b1000, 4'b0100, 4'd0};
    logic [3:0] bv [3] = '{4'd7, 4'd0, 4'b1111};
    for (int i = 0; i < 8; i++) begin
      if (i < 3) step(1'b0, 1'b1, ov[i], av[i], bv[i], 3'(i + 1), 1'b1);
      else       step(1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 3'd0, 1'b1);
      checks++;
      if (s_pop !== (i >= 3 && i <= 5)) begin
        errors++; $display("FAIL b2b_timing[%0d]: rsp_valid=%0b want %0b", i, s_pop, (i >= 3 && i <= 5));
      end
      if (s_pop) begin
        checks++;
        if (!e_ok || s_c !== e.c || s_tag !== e.tag || s_ovf !== e.ovf) begin
          errors++; $display("FAIL b2b_rsp[%0d]: got c=%0h tag=%0d ovf=%0b want c=%0h tag=%0d ovf=%0b",
                             i, s_c, s_tag, s_ovf, e.c, e.tag, e.ovf);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int acc_cnt = 0;
    int pop_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 2'($urandom_range(3)), 4'($urandom), 4'($urandom), 3'(i), 1'b0);
      if (s_acc) acc_cnt++;
    end
    checks++;
    if (acc_cnt != 4) begin errors++; $display("FAIL bp_accepts: got %0d want 4", acc_cnt); end
    checks++;
    if (s_req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %0b want 0", s_req_ready); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 3'd0, 1'b0);
      checks++;
      if (s_rsp_valid !== 1'b1 || s_busy !== 1'b1 || s_req_ready !== 1'b0 || s_c !== exp_q[0].c || s_tag !== exp_q[0].tag) begin
        errors++; $display("FAIL bp_hold[%0d]: rv=%0b busy=%0b rdy=%0b c=%0h tag=%0d want 1 1 0 c=%0h tag=%0d",
                           i, s_rsp_valid, s_busy, s_req_ready, s_c, s_tag, exp_q[0].c, exp_q[0].tag);
      end
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 3'd0, 1'b1);
      if (s_pop) begin
        pop_cnt++;
        checks++;
        if (!e_ok || s_c !== e.c || s_tag !== e.tag || s_ovf !== e.ovf) begin
          errors++; $display("FAIL bp_rsp[%0d]: got c=%0h tag=%0d ovf=%0b want c=%0h tag=%0d ovf=%0b",
                             i, s_c, s_tag, s_ovf, e.c, e.tag, e.ovf);
        end
      end
    end
    checks++;
    if (pop_cnt != 4) begin errors++; $display("FAIL bp_pops: got %0d want 4", pop_cnt); end
    checks++;
    if (s_req_ready !== 1'b1 || s_busy !== 1'b0) begin
      errors++; $display("FAIL bp_release: ready=%0b busy=%0b want 1 0", s_req_ready, s_busy);
    end
  endtask

  task automatic test_throughput();
    for (int i = 0; i < 23; i++) begin
      if (i < 20) step(1'b0, 1'b1, 2'($urandom_range(3)), 4'($urandom), 4'($urandom), 3'($urandom), 1'b1);
      else        step(1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 3'd0, 1'b1);
      if (i < 20) begin
        checks++;
        if (s_acc !== 1'b1) begin errors++; $display("FAIL tput_accept[%0d]: got %0b want 1", i, s_acc); end
      end
      checks++;
      if (s_pop !== (i >= 3)) begin errors++; $display("FAIL tput_timing[%0d]: rsp_valid=%0b want %0b", i, s_pop, (i >= 3)); end
      if (s_pop) begin
        checks++;
        if (!e_ok || s_c !== e.c || s_tag !== e.tag || s_ovf !== e.ovf) begin
          errors++; $display("FAIL tput_rsp[%0d]: got c=%0h tag=%0d ovf=%0b want c=%0h tag=%0d ovf=%0b",
                             i, s_c, s_tag, s_ovf, e.c, e.tag, e.ovf);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    int pop_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 2'($urandom_range(3)), 4'($urandom), 4'($urandom), 3'(i), 1'b0);
    end
    step(1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 3'd0, 1'b0);
    step(1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 3'd0, 1'b1);
    step(1'b0, 1'b1, 2'd0, 4'd3, 4'd2, 3'd6, 1'b1);
    checks++;
    if (s_rsp_valid !== 1'b0 || s_busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset_clear: rv=%0b busy=%0b want 0 0", s_rsp_valid, s_busy);
    end
    checks++;
    if (s_acc !== 1'b1) begin errors++; $display("FAIL mid_first_accept: got %0b want 1", s_acc); end
    step(1'b0, 1'b1, 2'd1, 4'd1, 4'd5, 3'd7, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 3'd0, 1'b1);
      if (s_pop) begin
        pop_cnt++;
        checks++;
        if (!e_ok || s_tag < 3'd6 || s_c !== e.c || s_tag !== e.tag || s_ovf !== e.ovf) begin
          errors++; $display("FAIL mid_rsp[%0d]: got c=%0h tag=%0d ovf=%0b want c=%0h tag=%0d ovf=%0b",
                             i, s_c, s_tag, s_ovf, e.c, e.tag, e.ovf);
        end
      end
    end
    checks++;
    if (pop_cnt != 2) begin errors++; $display("FAIL mid_pops: got %0d want 2", pop_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_back_to_back();
    test_backpressure();
    test_throughput();
    test_reset_midstream();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL leftover_results: got %0d want 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
